// File: rtl/tensor_loader_if.sv
// Stream-in / tensor-write bundle for tensor_loader.
// master: pixel source + tile consumer (drives s_*, tensor_ack);
// slave: the loader (drives s_ready, write port, status).
interface tensor_loader_if #(
    parameter int PIX_W = 8,
    parameter int WIDTH = 17
);
    logic [PIX_W-1:0] s_data;
    logic             s_valid;
    logic             s_first;
    logic             s_ready;
    logic             wr_en;
    logic [2:0]       row_addr;
    logic [2:0]       col_addr;
    logic [1:0]       cha_addr;
    logic [WIDTH-1:0] data_out;
    logic             tensor_valid;
    logic             tensor_ack;
    logic             sync_err;

    modport master (
        output s_data, s_valid, s_first, tensor_ack,
        input  s_ready, wr_en, row_addr, col_addr, cha_addr,
        input  data_out, tensor_valid, sync_err
    );

    modport slave (
        input  s_data, s_valid, s_first, tensor_ack,
        output s_ready, wr_en, row_addr, col_addr, cha_addr,
        output data_out, tensor_valid, sync_err
    );
endinterface

// File: rtl/tensor_loader.sv
// Raster pixel stream -> 8x8xNCH tensor writes with fixed-point conversion.
// Ports: clk, rst (sync, active-high), bus (tensor_loader_if.slave).
module tensor_loader #(
    parameter int WIDTH      = 17,
    parameter int PIX_W      = 8,
    parameter int NCH        = 3,
    parameter int ZERO_POINT = 128,
    parameter int FRAC_BITS  = 8
) (
    input  logic            clk,
    input  logic            rst,
    tensor_loader_if.slave  bus
);
    typedef enum logic [1:0] {FILL, DRAIN, HOLD} state_t;

    localparam logic [1:0]       CHA_LAST = 2'(NCH - 1);
    localparam logic [PIX_W-1:0] ZP       = PIX_W'(ZERO_POINT);
    localparam int SW = PIX_W + 1 + FRAC_BITS;
    // One guard bit above the wider of product and output.
    localparam int EW = ((SW > WIDTH) ? SW : WIDTH) + 1;
    localparam logic signed [EW-1:0] MAXV =
        {{(EW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [EW-1:0] MINV =
        {{(EW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

    state_t state;
    logic [2:0] row, col;
    logic [1:0] cha;

    logic       beat, last, nz;
    logic [2:0] e_row, e_col, n_row, n_col;
    logic [1:0] e_cha, n_cha;

    logic signed [PIX_W:0]  diff;
    logic signed [EW-1:0]   scaled;
    logic [WIDTH-1:0]       sat;

    assign beat = bus.s_valid && bus.s_ready;
    assign nz   = |{row, col, cha};

    // s_first forces the beat to element (0,0,0); the counters then
    // advance from there, which realigns a slipped stream.
    always_comb begin
        e_row = row;
        e_col = col;
        e_cha = cha;
        if (bus.s_first) begin
            e_row = '0;
            e_col = '0;
            e_cha = '0;
        end
        last  = (e_row == 3'd7) && (e_col == 3'd7)
             && (e_cha == CHA_LAST);
        n_row = e_row;
        n_col = e_col;
        n_cha = e_cha + 2'd1;
        if (e_cha == CHA_LAST) begin
            n_cha = '0;
            n_col = e_col + 3'd1;
            if (e_col == 3'd7) n_row = e_row + 3'd1;
        end
    end

    always_comb begin
        diff   = $signed({1'b0, bus.s_data}) - $signed({1'b0, ZP});
        scaled = EW'(diff) <<< FRAC_BITS;
        if (scaled > MAXV)
            sat = MAXV[WIDTH-1:0];
        else if (scaled < MINV)
            sat = MINV[WIDTH-1:0];
        else
            sat = scaled[WIDTH-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= FILL;
            row              <= '0;
            col              <= '0;
            cha              <= '0;
            bus.s_ready      <= 1'b1;
            bus.wr_en        <= 1'b0;
            bus.tensor_valid <= 1'b0;
            bus.sync_err     <= 1'b0;
            bus.row_addr     <= '0;
            bus.col_addr     <= '0;
            bus.cha_addr     <= '0;
            bus.data_out     <= '0;
        end else begin
            bus.wr_en <= beat;
            if (beat) begin
                bus.row_addr <= e_row;
                bus.col_addr <= e_col;
                bus.cha_addr <= e_cha;
                bus.data_out <= sat;
                row          <= n_row;
                col          <= n_col;
                cha          <= n_cha;
                if (bus.s_first && nz) bus.sync_err <= 1'b1;
            end
            unique case (state)
                FILL: begin
                    if (beat && last) begin
                        state       <= DRAIN;
                        bus.s_ready <= 1'b0;
                        row         <= '0;
                        col         <= '0;
                        cha         <= '0;
                    end
                end
                DRAIN: begin
                    state            <= HOLD;
                    bus.tensor_valid <= 1'b1;
                end
                HOLD: begin
                    if (bus.tensor_ack) begin
                        state            <= FILL;
                        bus.tensor_valid <= 1'b0;
                        bus.s_ready      <= 1'b1;
                    end
                end
                default: state <= FILL;
            endcase
        end
    end
endmodule

// File: tb/tb_tensor_loader.sv
// Scoreboard bench for tensor_loader: driver pushes expected writes,
// a negedge monitor pops and compares on every wr_en.
module tb_tensor_loader;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    tensor_loader_if #(.PIX_W(8), .WIDTH(17)) bus ();
    tensor_loader_if #(.PIX_W(8), .WIDTH(17)) busb ();
    tensor_loader_if #(.PIX_W(8), .WIDTH(17)) busc ();

    tensor_loader #(.WIDTH(17), .PIX_W(8), .NCH(3),
                    .ZERO_POINT(128), .FRAC_BITS(8))
        dut (.clk(clk), .rst(rst), .bus(bus));
    tensor_loader #(.WIDTH(17), .PIX_W(8), .NCH(3),
                    .ZERO_POINT(0), .FRAC_BITS(10))
        dut_b (.clk(clk), .rst(rst), .bus(busb));
    tensor_loader #(.WIDTH(17), .PIX_W(8), .NCH(3),
                    .ZERO_POINT(255), .FRAC_BITS(10))
        dut_c (.clk(clk), .rst(rst), .bus(busc));

    typedef struct {
        logic [2:0]  r;
        logic [2:0]  c;
        logic [1:0]  h;
        logic [16:0] d;
        int          wcyc;
    } exp_t;

    exp_t q[$];
    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int wr_count = 0;
    int last_wr_cyc = -1;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [16:0] conv(input int px, input int zp,
                                         input int fb);
        longint v;
        v = longint'(px - zp) * (longint'(1) << fb);
        if (v > 65535) v = 65535;
        if (v < -65536) v = -65536;
        return v[16:0];
    endfunction

    always @(negedge clk) begin
        if (!rst && bus.wr_en === 1'b1) begin
            exp_t e;
            wr_count++;
            last_wr_cyc = cyc;
            if (q.size() == 0) begin
                check("unexpected_wr_en", 1, 0);
            end else begin
                e = q.pop_front();
                check("wr_cycle", cyc, e.wcyc);
                check("row_addr", bus.row_addr, e.r);
                check("col_addr", bus.col_addr, e.c);
                check("cha_addr", bus.cha_addr, e.h);
                check("data_out", bus.data_out, e.d);
            end
        end
    end

    task automatic send(input logic [7:0] px, input logic first,
                        input logic [2:0] r, input logic [2:0] c,
                        input logic [1:0] h, input logic [16:0] d);
        int t = 0;
        exp_t e;
        bus.s_data  = px;
        bus.s_first = first;
        bus.s_valid = 1'b1;
        while (bus.s_ready !== 1'b1 && t < 100) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (t >= 100) begin
            check("s_ready_timeout", 0, 1);
        end else begin
            e.r = r; e.c = c; e.h = h; e.d = d;
            e.wcyc = cyc + 1;
            q.push_back(e);
        end
        @(posedge clk);
        #1;
        bus.s_valid = 1'b0;
        bus.s_first = 1'b0;
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.s_data = '0;  bus.s_valid = 0;  bus.s_first = 0;
        bus.tensor_ack = 0;
        busb.s_data = '0; busb.s_valid = 0; busb.s_first = 0;
        busb.tensor_ack = 0;
        busc.s_data = '0; busc.s_valid = 0; busc.s_first = 0;
        busc.tensor_ack = 0;
        rst = 1'b1;
        tick(3);
        check("rst_wr_en", bus.wr_en, 0);
        check("rst_tensor_valid", bus.tensor_valid, 0);
        check("rst_sync_err", bus.sync_err, 0);
        check("rst_s_ready", bus.s_ready, 1);
        check("rst_addr", {bus.row_addr, bus.col_addr, bus.cha_addr}, 0);
        check("rst_data", bus.data_out, 0);
        rst = 1'b0;

        // Full tile, back-to-back
        for (int i = 0; i < 192; i++) begin
            logic [16:0] d;
            d = (i == 0) ? 17'h18000 : conv(i % 256, 128, 8);
            send(8'(i % 256), i == 0, 3'(i / 24), 3'((i / 3) % 8),
                 2'(i % 3), d);
        end
        check("drain_s_ready", bus.s_ready, 0);
        check("drain_tensor_valid", bus.tensor_valid, 0);
        tick(1);
        check("tv_rise", bus.tensor_valid, 1);
        check("tv_after_last_wr", last_wr_cyc, cyc - 1);
        check("tile_wr_count", wr_count, 192);

        // Hold with upstream pushing
        bus.s_valid = 1'b1;
        bus.s_data  = 8'd255;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            check("hold_tv", bus.tensor_valid, 1);
            check("hold_no_wr", bus.wr_en, 0);
        end
        bus.s_valid = 1'b0;
        bus.tensor_ack = 1'b1;
        tick(1);
        bus.tensor_ack = 1'b0;
        check("release_s_ready", bus.s_ready, 1);
        check("release_tv", bus.tensor_valid, 0);
        send(8'd255, 1'b0, 3'd0, 3'd0, 2'd0, 17'h07F00);
        send(8'd128, 1'b0, 3'd0, 3'd0, 2'd1, 17'h00000);

        // Bubbles
        for (int i = 2; i < 12; i++) begin
            tick($urandom_range(0, 3));
            send(8'(i * 7), 1'b0, 3'd0, 3'(i / 3), 2'(i % 3),
                 conv(i * 7, 128, 8));
        end
        tick(2);

        // Reset mid-tile, then resync on beat 5
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("post_rst_wr_en", bus.wr_en, 0);
        for (int i = 0; i < 5; i++)
            send(8'(40 + i), i == 0, 3'd0, 3'(i / 3), 2'(i % 3),
                 conv(40 + i, 128, 8));
        check("pre_resync_err", bus.sync_err, 0);
        send(8'd200, 1'b1, 3'd0, 3'd0, 2'd0, conv(200, 128, 8));
        check("resync_err", bus.sync_err, 1);
        send(8'd201, 1'b0, 3'd0, 3'd0, 2'd1, conv(201, 128, 8));
        tick(2);
        check("sticky_err", bus.sync_err, 1);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("rst_clears_err", bus.sync_err, 0);
        send(8'd10, 1'b0, 3'd0, 3'd0, 2'd0, conv(10, 128, 8));
        tick(2);

        // Saturation instances
        busb.s_data = 8'd255; busb.s_valid = 1'b1;
        busc.s_data = 8'd0;   busc.s_valid = 1'b1;
        tick(1);
        busb.s_valid = 1'b0;
        busc.s_valid = 1'b0;
        check("sat_hi_wr", busb.wr_en, 1);
        check("sat_hi", busb.data_out, 17'h0FFFF);
        check("sat_lo_wr", busc.wr_en, 1);
        check("sat_lo", busc.data_out, 17'h10000);

        tick(3);
        check("scoreboard_empty", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/tensor_loader.md
Name: tensor_loader

Overview:
- Upstream feeder for the 8x8xC tensor builder stage.
- Accepts a valid/ready stream of unsigned pixel samples in raster order: channel fastest, then column, then row.
- Converts each sample to signed fixed point and issues one registered write per sample as a row/col/channel address plus data word.
- After the last element of a tile, signals tensor completion and holds off input until the consumer acknowledges.

Parameters:
- WIDTH, 17, width of the signed output data word (matches tensor element width).
- PIX_W, 8, width of the unsigned input pixel.
- NCH, 3, channels per pixel position (1..4).
- ZERO_POINT, 128, value subtracted from each pixel before scaling (0..2^PIX_W-1).
- FRAC_BITS, 8, left shift applied after zero-point subtraction.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- s_data  in  PIX_W  input pixel sample
- s_valid  in  1  sample valid
- s_first  in  1  sample is element (0,0,0) of a tile; qualified by s_valid
- s_ready  out  1  block accepts a sample this cycle
- wr_en  out  1  write strobe to the tensor stage
- row_addr  out  3  write row
- col_addr  out  3  write column
- cha_addr  out  2  write channel
- data_out  out  WIDTH  signed converted sample
- tensor_valid  out  1  complete tile is resident downstream
- tensor_ack  in  1  consumer has taken the tile
- sync_err  out  1  sticky: s_first seen mid-tile

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous, active-high; it overrides all other inputs.
- Reset values:
  - state = FILL; all counters 0.
  - wr_en, tensor_valid and sync_err are 0.
  - row_addr, col_addr, cha_addr and data_out are 0.
- States:
  - FILL: s_ready=1.
  - DRAIN: s_ready=0, one cycle only.
  - HOLD: s_ready=0, tensor_valid=1.
- Beat: s_valid && s_ready at a rising edge.
- Write latency:
  - A beat at cycle k gives wr_en=1 at cycle k+1, with the address and data of that beat registered.
  - wr_en=0 in any cycle with no beat in the preceding cycle.
- Counters:
  - cha increments on each beat; it wraps at NCH-1 to 0 and carries into col.
  - col wraps at 7 and carries into row.
- Last beat: the beat with row=7, col=7, cha=NCH-1 (NCH*64 beats per tile).
  - FILL goes to DRAIN; counters return to 0.
  - DRAIN always goes to HOLD on the next cycle, so tensor_valid rises the cycle after the last wr_en.
- HOLD exit: tensor_valid stays 1 until a cycle with tensor_ack=1, then the state returns to FILL on the next edge.
  - tensor_ack outside HOLD is ignored.
  - No beat is accepted in DRAIN or HOLD.
- Resync on s_first:
  - If a beat has s_first=1 while the counters are non-zero, sync_err is set (sticky until rst).
  - That beat is written as element (0,0,0) and the counters continue from (0,0,1), or from (0,1,0) when NCH=1.
  - s_first on a beat with the counters already at 0 is normal.
- Conversion:
  - diff = s_data - ZERO_POINT as a signed (PIX_W+1)-bit value.
  - scaled = diff * 2^FRAC_BITS, evaluated without overflow.
  - Saturate to the signed WIDTH range: max 2^(WIDTH-1)-1, min -2^(WIDTH-1).
- Output holding: data_out and the address outputs hold their last value when wr_en=0.
- Reset mid-tile: all state is discarded and the next beat is element (0,0,0); nothing is written in the cycle after rst.

Test Plan:
- Full tile, NCH=3, ZP=128, FRAC=8, s_valid held high, data = beat index mod 256:
  - Exactly 192 wr_en pulses.
  - Beat 0 writes (0,0,0) with data_out=17'h18000 (-32768).
  - Beat 191 writes (7,7,2).
  - tensor_valid rises exactly 1 cycle after the final wr_en; s_ready=0 from the cycle after beat 191.
- Hold and release: keep tensor_ack=0 for 10 cycles with s_valid=1.
  - No wr_en; tensor_valid stays 1.
  - Pulse tensor_ack: the next cycle is FILL and the next beat writes (0,0,0).
- Conversion extremes, FRAC=8, ZP=128:
  - pixel 255 gives 17'h07F00 (32512).
  - pixel 128 gives 0.
- Saturation, FRAC=10, ZP=0:
  - pixel 255 gives 17'h0FFFF.
  - With ZP=255, pixel 0 gives 17'h10000.
- Bubbles: random s_valid gaps.
  - wr_en only in the cycle after each beat.
  - Addresses are contiguous across the gaps.
- Resync: s_first=1 on beat 5.
  - sync_err=1 from then on, and that beat writes (0,0,0).
  - After rst, sync_err=0 and a beat in the cycle following rst deassertion writes (0,0,0).
